stream_fifo: RTL and testbench



---
 rtl/stream_fifo.sv | 143 ++++++++++++++
 tb/tb_stream_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo
//   Single-clock stream FIFO that buffers pixel words between the bus write
//   side and the RAMDAC pixel pipeline. All DEPTH slots are usable. The fill
//   level is held in a register, and the almost-full/almost-empty flags are
//   derived from it. A synchronous flush discards all contents. The output
//   is either show-ahead (first-word-fall-through) or a registered read with
//   one cycle of latency.
//
// Ports
//   clock        sole clock; all state updates on its rising edge
//   reset_n      asynchronous active-low reset
//   flush        synchronous discard of all contents (beats push/pop)
//   in_data      write word
//   in_valid     write request
//   in_ready     FIFO can accept a word this cycle (registered state only)
//   out_data     read word
//   out_valid    out_data is valid
//   out_ready    consumer accepts / requests a word
//   level        number of stored entries, 0..DEPTH
//   almost_full  level >= ALMOST_FULL_LEVEL
//   almost_empty level <= ALMOST_EMPTY_LEVEL
module stream_fifo #(
  parameter int BUS_WIDTH          = 12,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDRESS_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int SHOW_AHEAD         = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [BUS_WIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BUS_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDRESS_WIDTH:0] level,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL_LVL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] PTR_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH:0] AF_LVL   = ALMOST_FULL_LEVEL[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH:0] AE_LVL   = ALMOST_EMPTY_LEVEL[ADDRESS_WIDTH:0];

  logic [BUS_WIDTH-1:0]   mem_q [DEPTH];
  // Pointers carry one extra wrap bit; the low bits index the array.
  logic [ADDRESS_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH:0] level_q, level_d;
  logic                   full, empty, push, pop;
  logic [BUS_WIDTH-1:0]   head;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // in_ready depends only on registered state, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // In both output modes a pop is out_ready with a non-empty FIFO
  // (in show-ahead mode out_valid is exactly !empty).
  assign pop      = out_ready && !empty;
  assign head     = mem_q[rd_ptr_q[ADDRESS_WIDTH-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + PTR_ONE;
        2'b01:   level_d = level_q - PTR_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q[ADDRESS_WIDTH-1:0]] <= in_data;
  end

  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign out_valid = !empty;
      assign out_data  = head;
    end else begin : g_registered
      logic                 out_valid_q, out_valid_d;
      logic [BUS_WIDTH-1:0] out_data_q, out_data_d;

      // The output register is zeroed on any cycle without a pop, so
      // out_data reads 0 whenever out_valid is low.
      always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        if (!flush && pop) begin
          out_valid_d = 1'b1;
          out_data_d  = head;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_data_q  <= out_data_d;
        end
      end

      assign out_valid = out_valid_q;
      assign out_data  = out_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;
  localparam int W = 12;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  // Show-ahead instance
  logic in_ready_a, out_valid_a, af_a, ae_a;
  logic [W-1:0] out_data_a;
  logic [AW:0] level_a;
  // Registered-read instance
  logic in_ready_b, out_valid_b, af_b, ae_b;
  logic [W-1:0] out_data_b;
  logic [AW:0] level_b;

  stream_fifo #(.BUS_WIDTH(W), .ADDRESS_WIDTH(AW), .SHOW_AHEAD(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .level(level_a), .almost_full(af_a), .almost_empty(ae_a));

  stream_fifo #(.BUS_WIDTH(W), .ADDRESS_WIDTH(AW), .SHOW_AHEAD(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .level(level_b), .almost_full(af_b), .almost_empty(ae_b));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus the registered-read output.
  logic [W-1:0] mq[$];
  logic         eb_ov = 1'b0;
  logic [W-1:0] eb_od = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("level_a", 32'(level_a), n);
    chk("in_ready_a", 32'(in_ready_a), 32'(n < DEPTH));
    chk("out_valid_a", 32'(out_valid_a), 32'(n != 0));
    if (n != 0) chk("out_data_a", 32'(out_data_a), 32'(mq[0]));
    chk("almost_full_a", 32'(af_a), 32'(n >= DEPTH - 2));
    chk("almost_empty_a", 32'(ae_a), 32'(n <= 2));
    chk("level_b", 32'(level_b), n);
    chk("in_ready_b", 32'(in_ready_b), 32'(n < DEPTH));
    chk("almost_full_b", 32'(af_b), 32'(n >= DEPTH - 2));
    chk("almost_empty_b", 32'(ae_b), 32'(n <= 2));
    chk("out_valid_b", 32'(out_valid_b), 32'(eb_ov));
    chk("out_data_b", 32'(out_data_b), 32'(eb_od));
  endtask

  // One clock with the currently driven inputs, then model update and check.
  task automatic cycle();
    bit do_push, do_pop;
    logic [W-1:0] hd;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() > 0);
    @(posedge clock);
    #1;
    if (flush) begin
      mq.delete();
      eb_ov = 1'b0;
      eb_od = '0;
    end else begin
      eb_ov = do_pop;
      eb_od = '0;
      if (do_pop) begin
        hd = mq.pop_front();
        eb_od = hd;
      end
      if (do_push) mq.push_back(in_data);
    end
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_cnt;
    // Reset state
    #3;
    check_all();
    chk("reset_out_data_b", 32'(out_data_b), 32'h0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // Fill: 0x001..0x010, then a 17th attempt that must be refused
    in_valid = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      in_data = W'(i);
      cycle();
    end
    chk("full_level", 32'(level_a), 32'd16);
    in_data = 12'h0FF;
    cycle();
    in_valid = 1'b0;

    // Drain
    out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_order", 32'(out_data_a), 32'(i));
      cycle();
    end
    chk("drained_valid", 32'(out_valid_a), 32'h0);
    out_ready = 1'b0;

    // Concurrent push/pop at level 5 with pointer wraps
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = W'(12'h100 + i);
      cycle();
    end
    out_ready = 1'b1;
    wrap_cnt = 0;
    for (int i = 5; i < 45; i++) begin
      in_data = W'(12'h100 + i);
      cycle();
      chk("steady_level", 32'(level_a), 32'd5);
    end

    // Flush at level 9 with a concurrent push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(12'h200 + i);
      cycle();
    end
    chk("pre_flush_level", 32'(level_a), 32'd9);
    flush = 1'b1;
    out_ready = 1'b1;
    in_data = 12'hEEE;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();

    // Registered-read latency: 0x123, 0x456 then hold out_ready
    in_valid = 1'b1;
    in_data = 12'h123; cycle();
    in_data = 12'h456; cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("ra_first", 32'(out_data_b), 32'h123);
    cycle();
    chk("ra_second", 32'(out_data_b), 32'h456);
    cycle();
    chk("ra_after_valid", 32'(out_valid_b), 32'h0);
    chk("ra_after_data", 32'(out_data_b), 32'h0);
    out_ready = 1'b0;

    // Randomized traffic, two bias phases, occasional flush
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 4) < 2);
      end else begin
        in_valid  = ($urandom_range(0, 4) < 2);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      flush = ($urandom_range(0, 63) == 0);
      in_data = W'($urandom);
      cycle();
    end
    flush = 1'b0;

    // Async reset mid-stream, between edges
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = W'(12'h300 + i);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    eb_ov = 1'b0;
    eb_od = '0;
    check_all();
    out_ready = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data = 12'hABC;
    cycle();
    in_valid = 1'b0;
    in_data = 12'h555;
    chk("post_reset_head", 32'(out_data_a), 32'hABC);
    out_ready = 1'b1;
    cycle();
    chk("post_reset_b", 32'(out_data_b), 32'hABC);
    out_ready = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
